// File: rtl/div_defs.sv
// rtl/div_defs.sv - shared definitions for the restoring-division sequencer
package div_defs;

    // Default operand/result width; the iteration count equals this width.
    localparam int DIV_WIDTH = 32;

    // Quotient reported on divide-by-zero at the default width (all ones).
    localparam logic [DIV_WIDTH-1:0] DBZ_QUOT = {DIV_WIDTH{1'b1}};

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_ITER = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } div_state_e;

endpackage

// File: rtl/div_trial_sub.sv
// rtl/div_trial_sub.sv - combinational (WIDTH+1)-bit trial subtract
//
// Ports:
//   minuend_i     [WIDTH:0]  shifted partial remainder
//   subtrahend_i  [WIDTH:0]  zero-extended divisor magnitude
//   diff_o        [WIDTH:0]  minuend_i - subtrahend_i
//   nonneg_o                 1 when the subtraction did not borrow
module div_trial_sub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0] minuend_i,
    input  logic [WIDTH:0] subtrahend_i,
    output logic [WIDTH:0] diff_o,
    output logic           nonneg_o
);

    // One extra bit catches the borrow out of the unsigned subtract.
    logic [WIDTH+1:0] full_diff;

    assign full_diff = {1'b0, minuend_i} - {1'b0, subtrahend_i};
    assign diff_o    = full_diff[WIDTH:0];
    assign nonneg_o  = ~full_diff[WIDTH+1];

endmodule

// File: rtl/div_seq_ctrl.sv
// rtl/div_seq_ctrl.sv - multi-cycle restoring-division sequencer (LO=quotient, HI=remainder)
//
// Build option: define SIGNED_DIV_EN for two's-complement operands (quotient
// truncates toward zero, remainder takes the dividend's sign). Undefined gives
// a purely unsigned divider with identical timing.
//
// Ports:
//   clk          system clock, rising edge
//   clr          asynchronous active-low reset
//   start        request pulse, sampled only in IDLE
//   dividend     Ra operand, captured on accepted start
//   divisor      Rb operand, captured on accepted start
//   busy         high from accepting start until done is raised
//   done         one-cycle pulse, results valid and held afterwards
//   quotient     LO result
//   remainder    HI result
//   div_by_zero  set with done when the divisor was zero
module div_seq_ctrl
    import div_defs::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_e       state_q;
    logic [WIDTH:0]   a_q;        // partial remainder
    logic [WIDTH-1:0] q_q;        // dividend magnitude shifting into quotient
    logic [WIDTH-1:0] d_q;        // divisor (magnitude after PREP)
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             dbz_q;
`ifdef SIGNED_DIV_EN
    logic             neg_quot_q;
    logic             neg_rem_q;
`endif

    // {A,Q} shifted left one place; A's top bit drops out because the partial
    // remainder is always below the divisor and so never reaches it.
    logic [WIDTH:0] a_shift;
    logic [WIDTH:0] diff_d;
    logic           nonneg_d;
    logic           unused_a_msb;

    assign a_shift      = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign unused_a_msb = a_q[WIDTH];

    div_trial_sub #(
        .WIDTH(WIDTH)
    ) u_trial_sub (
        .minuend_i   (a_shift),
        .subtrahend_i({1'b0, d_q}),
        .diff_o      (diff_d),
        .nonneg_o    (nonneg_d)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
`ifdef SIGNED_DIV_EN
            neg_quot_q  <= 1'b0;
            neg_rem_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        q_q     <= dividend;
                        d_q     <= divisor;
                        busy_q  <= 1'b1;
                        dbz_q   <= 1'b0;
                        state_q <= ST_PREP;
                    end
                end

                ST_PREP: begin
                    if (d_q == '0) begin
                        // q_q still holds the raw dividend here.
                        quotient_q  <= '1;
                        remainder_q <= q_q;
                        dbz_q       <= 1'b1;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        a_q   <= '0;
                        cnt_q <= '0;
`ifdef SIGNED_DIV_EN
                        // -2^(WIDTH-1) negates to itself, which is still the
                        // correct unsigned magnitude.
                        q_q        <= q_q[WIDTH-1] ? -q_q : q_q;
                        d_q        <= d_q[WIDTH-1] ? -d_q : d_q;
                        neg_quot_q <= q_q[WIDTH-1] ^ d_q[WIDTH-1];
                        neg_rem_q  <= q_q[WIDTH-1];
`endif
                        state_q <= ST_ITER;
                    end
                end

                ST_ITER: begin
                    a_q <= nonneg_d ? diff_d : a_shift;
                    q_q <= {q_q[WIDTH-2:0], nonneg_d};
                    if (cnt_q == LAST_CNT) begin
                        state_q <= ST_FIX;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                ST_FIX: begin
`ifdef SIGNED_DIV_EN
                    quotient_q  <= neg_quot_q ? -q_q : q_q;
                    remainder_q <= neg_rem_q ? -a_q[WIDTH-1:0] : a_q[WIDTH-1:0];
`else
                    quotient_q  <= q_q;
                    remainder_q <= a_q[WIDTH-1:0];
`endif
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_DONE;
                end

                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb/tb_div_seq_ctrl.sv - self-checking bench for div_seq_ctrl
module tb_div_seq_ctrl;

    localparam int W = 32;

    logic         clk;
    logic         clr;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_total = 0;
    int n_bad   = 0;

    div_seq_ctrl #(
        .WIDTH(W)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain arithmetic on the operands as the ISA defines them.
    task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
        longint sa, sb;
        if (b == 0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else begin
`ifdef SIGNED_DIV_EN
            sa = longint'($signed(a));
            sb = longint'($signed(b));
`else
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
`endif
            q = W'(sa / sb);
            r = W'(sa % sb);
            z = 1'b0;
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the
    // first legal IDLE cycle so consecutive calls are back-to-back.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez,
                          input bit spam, input string tag);
        int k;
        int busy_cnt;
        int exp_lat;
        exp_lat = ez ? 1 : W + 2;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        k        = 0;
        busy_cnt = 0;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        while (!done && k < 200) begin
            if (busy) busy_cnt++;
            if (spam) begin
                start    = 1'($urandom_range(0, 1));
                dividend = $urandom;
                divisor  = $urandom;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        check_eq({tag, ".latency"}, W'(k), W'(exp_lat));
        check_eq({tag, ".busy_cycles"}, W'(busy_cnt), W'(exp_lat));
        check_eq({tag, ".busy_at_done"}, W'(busy), '0);
        check_eq({tag, ".quotient"}, quotient, eq);
        check_eq({tag, ".remainder"}, remainder, er);
        check_eq({tag, ".dbz"}, W'(div_by_zero), W'(ez));
        @(negedge clk);
        check_eq({tag, ".done_pulse"}, W'(done), '0);
        check_eq({tag, ".q_held"}, quotient, eq);
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } vec_t;

    vec_t dir[$];

    initial begin
        logic [W-1:0] ra, rb, eq, er;
        logic         ez;
        int           sel;
        int           seen_done;

        dir.push_back('{32'd9, 32'd1, 32'h0000_0009, 32'd0, 1'b0});
`ifdef SIGNED_DIV_EN
        dir.push_back('{32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0});
        dir.push_back('{32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0});
        dir.push_back('{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0});
        dir.push_back('{32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1});
`else
        dir.push_back('{32'hFFFF_FFFF, 32'h0000_00FF, 32'h0101_0101, 32'd0, 1'b0});
        dir.push_back('{32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0});
`endif
        dir.push_back('{32'd100, 32'd7, 32'd14, 32'd2, 1'b0});
        dir.push_back('{32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1});
        dir.push_back('{32'd8, 32'd2, 32'd4, 32'd0, 1'b0});

        clr      = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        check_eq("reset.busy", W'(busy), '0);
        check_eq("reset.done", W'(done), '0);
        check_eq("reset.quotient", quotient, '0);
        check_eq("reset.remainder", remainder, '0);
        check_eq("reset.dbz", W'(div_by_zero), '0);
        clr = 1'b1;
        @(negedge clk);

        // Directed vectors, issued back-to-back.
        foreach (dir[i]) begin
            run_op(dir[i].a, dir[i].b, dir[i].q, dir[i].r, dir[i].z, 1'b0, $sformatf("dir%0d", i));
        end

        // Starts while busy must be ignored.
        run_op(32'd1000, 32'd33, 32'd30, 32'd10, 1'b0, 1'b1, "spam");

        // Abort mid-iteration with reset.
        start    = 1'b1;
        dividend = 32'd12345;
        divisor  = 32'd11;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        clr = 1'b0;
        #1;
        check_eq("abort.busy", W'(busy), '0);
        check_eq("abort.done", W'(done), '0);
        check_eq("abort.quotient", quotient, '0);
        check_eq("abort.remainder", remainder, '0);
        check_eq("abort.dbz", W'(div_by_zero), '0);
        @(negedge clk);
        clr = 1'b1;
        seen_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        check_eq("abort.no_done", W'(seen_done), '0);
        run_op(32'd12345, 32'd11, 32'd1122, 32'd3, 1'b0, 1'b0, "after_abort");

        // Randomized operands against the reference.
        for (int i = 0; i < 24; i++) begin
            ra  = $urandom;
            sel = $urandom_range(0, 5);
            case (sel)
                0:       rb = '0;
                1:       rb = W'($urandom_range(1, 15));
                2:       rb = ra;
                3:       rb = $urandom;
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            ref_div(ra, rb, eq, er, ez);
            run_op(ra, rb, eq, er, ez, (i % 3) == 1, $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
